// File: rtl/ctrl_pkg.sv
// Shared decode constants, FSM state encoding and instruction-length helper
// for the control sequencer.
package ctrl_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;  // type=1 is CAL
   localparam logic [3:0] OP_CMP = 4'h1;
   localparam logic [3:0] OP_JMP = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_MAS = 4'h6;
   localparam logic [3:0] OP_MOV = 4'h7;
   localparam logic [3:0] OP_PLD = 4'h8;
   localparam logic [3:0] OP_PST = 4'h9;
   localparam logic [3:0] OP_SET = 4'hB;
   localparam logic [3:0] OP_LSL = 4'hC;
   localparam logic [3:0] OP_LSR = 4'hD;
   localparam logic [3:0] OP_RTN = 4'hE;
   localparam logic [3:0] OP_STP = 4'hF;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } state_t;

   // Type bit selects a second word, except STP which stays single-word.
   function automatic logic is_two_word(input logic [3:0] op, input logic typ);
      return typ && (op != OP_STP);
   endfunction

endpackage

// File: rtl/ctrl_sequencer_ret_stack.sv
// Return-address stack for CAL/RTN. Push and pop are mutually exclusive;
// a push when full or a pop when empty is ignored here and flagged by the caller.
module ret_stack #(
   parameter int STACK_DEPTH = 8,
   parameter int ADDR_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [ADDR_W-1:0]             din,
   output logic [ADDR_W-1:0]             dout,
   output logic [$clog2(STACK_DEPTH):0]  sp,
   output logic                          full,
   output logic                          empty
);

   localparam int IDX_W = $clog2(STACK_DEPTH);

   logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
   logic [IDX_W:0]    sp_q, sp_d;
   logic [IDX_W-1:0]  top_idx;

   assign full    = (sp_q == (IDX_W+1)'(STACK_DEPTH));
   assign empty   = (sp_q == '0);
   assign top_idx = sp_q[IDX_W-1:0] - IDX_W'(1);
   assign dout    = mem_q[top_idx];
   assign sp      = sp_q;

   // Occupancy update; overflow/underflow requests leave the pointer alone.
   always_comb begin
      sp_d = sp_q;
      if (push && !full) begin
         sp_d = sp_q + (IDX_W+1)'(1);
      end else if (pop && !empty) begin
         sp_d = sp_q - (IDX_W+1)'(1);
      end
   end

   // Stack pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Entry storage; a push coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && push && !full) begin
         mem_q[sp_q[IDX_W-1:0]] <= din;
      end
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered instruction sequencer: owns the PC, runs each instruction as a
// FETCH/EXEC pair, decodes write strobes and resolves JMP/CMP/CAL/RTN/STP.
//
//   state | meaning
//   FETCH | instruction memory addressed by pc / pc+1, no strobes
//   EXEC  | instr/imm valid, strobes asserted, pc updated
//   HALT  | pc held after STP, leaves when run=1
//   FAULT | return-stack over/underflow, only reset leaves
module ctrl_sequencer #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int STACK_DEPTH = 8,
   parameter int RESET_PC    = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run,
   input  logic [DATA_W-1:0]             instr,
   input  logic [DATA_W-1:0]             imm,
   input  logic [DATA_W-1:0]             rddata,
   input  logic [DATA_W-1:0]             rsdata,
   input  logic                          jump,
   output logic [ADDR_W-1:0]             instr_addr1,
   output logic [ADDR_W-1:0]             instr_addr2,
   output logic [ADDR_W-1:0]             pc,
   output logic [ADDR_W-1:0]             data_addr1,
   output logic [ADDR_W-1:0]             data_addr2,
   output logic                          rd_wen,
   output logic                          rs_wen,
   output logic                          data_wen1,
   output logic                          data_wen2,
   output logic                          mux1_sel,
   output logic                          halted,
   output logic                          fault,
   output logic [$clog2(STACK_DEPTH):0]  sp
);

   import ctrl_pkg::*;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] data_addr1_q, data_addr1_d;
   logic [ADDR_W-1:0] data_addr2_q, data_addr2_d;

   logic [3:0]        op;
   logic              typ;
   logic [ADDR_W-1:0] pc_len;
   logic [ADDR_W-1:0] pc_ret;
   logic              st_push, st_pop, st_full, st_empty;
   logic [ADDR_W-1:0] st_top;
   logic              unused_bits;

   assign op     = instr[15:12];
   assign typ    = instr[11];
   assign pc_len = pc_q + (is_two_word(op, typ) ? ADDR_W'(2) : ADDR_W'(1));
   assign pc_ret = pc_q + ADDR_W'(2);

   // Only the opcode, type and low operand bits drive decode.
   assign unused_bits = ^{instr[10:4], imm, rddata, rsdata};

   ret_stack #(
      .STACK_DEPTH (STACK_DEPTH),
      .ADDR_W      (ADDR_W)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (st_push),
      .pop   (st_pop),
      .din   (pc_ret),
      .dout  (st_top),
      .sp    (sp),
      .full  (st_full),
      .empty (st_empty)
   );

   // Next-state, next-pc and EXEC strobe decode.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      data_addr1_d = data_addr1_q;
      data_addr2_d = data_addr2_q;
      rd_wen       = 1'b0;
      rs_wen       = 1'b0;
      data_wen1    = 1'b0;
      data_wen2    = 1'b0;
      mux1_sel     = 1'b0;
      st_push      = 1'b0;
      st_pop       = 1'b0;
      case (state_q)
         FETCH: state_d = EXEC;
         EXEC: begin
            state_d = FETCH;
            pc_d    = pc_len;
            case (op)
               OP_NOP: begin
                  if (typ) begin
                     if (st_full) begin
                        state_d = FAULT;
                        pc_d    = pc_q;
                     end else begin
                        st_push = 1'b1;
                        pc_d    = imm[ADDR_W-1:0];
                     end
                  end
               end
               OP_CMP: begin
                  if (jump) pc_d = pc_len + ADDR_W'(instr[1:0]);
               end
               OP_JMP: pc_d = typ ? imm[ADDR_W-1:0] : rddata[ADDR_W-1:0];
               OP_ADD, OP_SUB, OP_MAS, OP_MOV: rd_wen = 1'b1;
               OP_PLD: begin
                  if (!typ) begin
                     rd_wen = instr[3];
                     rs_wen = instr[2];
                  end
               end
               OP_PST: begin
                  if (!typ) begin
                     data_wen1 = instr[3];
                     data_wen2 = instr[2];
                     mux1_sel  = 1'b1;
                  end
               end
               OP_SET: begin
                  data_addr1_d = rddata[ADDR_W-1:0];
                  data_addr2_d = rsdata[ADDR_W-1:0];
               end
               OP_LSL, OP_LSR: begin
                  if (!typ) rd_wen = 1'b1;
               end
               OP_RTN: begin
                  if (!typ) begin
                     if (st_empty) begin
                        state_d = FAULT;
                        pc_d    = pc_q;
                     end else begin
                        st_pop = 1'b1;
                        pc_d   = st_top;
                     end
                  end
               end
               OP_STP: begin
                  if (typ) state_d = HALT;
               end
               default: ;
            endcase
         end
         HALT:  if (run) state_d = FETCH;
         FAULT: state_d = FAULT;
         default: state_d = FETCH;
      endcase
   end

   // State, pc and data-address registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FETCH;
         pc_q         <= ADDR_W'(RESET_PC);
         data_addr1_q <= '0;
         data_addr2_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         data_addr1_q <= data_addr1_d;
         data_addr2_q <= data_addr2_d;
      end
   end

   assign pc          = pc_q;
   assign instr_addr1 = pc_q;
   assign instr_addr2 = pc_q + ADDR_W'(1);
   assign data_addr1  = data_addr1_q;
   assign data_addr2  = data_addr2_q;
   assign halted      = (state_q == HALT) || (state_q == FAULT);
   assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer with a synchronous-read instruction memory model.
module tb_ctrl_sequencer;

   logic        clk = 1'b0;
   logic        reset, run, jump;
   logic [15:0] instr, imm, rddata, rsdata;
   logic [15:0] instr_addr1, instr_addr2, pc, data_addr1, data_addr2;
   logic        rd_wen, rs_wen, data_wen1, data_wen2, mux1_sel, halted, fault;
   logic [3:0]  sp;

   logic [15:0] mem [0:65535];
   int          n_total = 0;
   int          n_pass  = 0;

   ctrl_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .instr       (instr),
      .imm         (imm),
      .rddata      (rddata),
      .rsdata      (rsdata),
      .jump        (jump),
      .instr_addr1 (instr_addr1),
      .instr_addr2 (instr_addr2),
      .pc          (pc),
      .data_addr1  (data_addr1),
      .data_addr2  (data_addr2),
      .rd_wen      (rd_wen),
      .rs_wen      (rs_wen),
      .data_wen1   (data_wen1),
      .data_wen2   (data_wen2),
      .mux1_sel    (mux1_sel),
      .halted      (halted),
      .fault       (fault),
      .sp          (sp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      instr <= mem[instr_addr1];
      imm   <= mem[instr_addr2];
   end

   typedef struct {
      logic [15:0] addr;
      logic [15:0] ins;
      logic [15:0] immw;
      logic [15:0] rd;
      logic [15:0] rs;
      logic        jmp;
      logic [15:0] exp_pc;
      logic [4:0]  exp_stb;   // {rd_wen, rs_wen, data_wen1, data_wen2, mux1_sel}
      logic [15:0] exp_da1;
      logic [15:0] exp_da2;
   } vec_t;

   vec_t vecs [20];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic [4:0] strobes();
      return {rd_wen, rs_wen, data_wen1, data_wen2, mux1_sel};
   endfunction

   initial begin
      logic [5:0]  trace;
      logic [15:0] a1;
      vec_t        v;

      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
      reset = 1'b1; run = 1'b0; jump = 1'b0; rddata = '0; rsdata = '0;

      //            addr      ins       imm       rd        rs      jmp  exp_pc    stb       da1       da2
      vecs[0]  = '{16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 5'b10000, 16'h0000, 16'h0000};
      vecs[1]  = '{16'h0000, 16'h2800, 16'h0040, 16'h0000, 16'h0000, 1'b0, 16'h0040, 5'b00000, 16'h0000, 16'h0000};
      vecs[2]  = '{16'h0000, 16'h2000, 16'h0000, 16'h0123, 16'h0000, 1'b0, 16'h0123, 5'b00000, 16'h0000, 16'h0000};
      vecs[3]  = '{16'h0010, 16'h1003, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0014, 5'b00000, 16'h0000, 16'h0000};
      vecs[4]  = '{16'h0010, 16'h1003, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0011, 5'b00000, 16'h0000, 16'h0000};
      vecs[5]  = '{16'h0010, 16'h1802, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0014, 5'b00000, 16'h0000, 16'h0000};
      vecs[6]  = '{16'h0000, 16'h900C, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 5'b00111, 16'h0000, 16'h0000};
      vecs[7]  = '{16'h0000, 16'h9008, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 5'b00101, 16'h0000, 16'h0000};
      vecs[8]  = '{16'h0000, 16'h800C, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 5'b11000, 16'h0000, 16'h0000};
      vecs[9]  = '{16'h0000, 16'h8004, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 5'b01000, 16'h0000, 16'h0000};
      vecs[10] = '{16'h0000, 16'hB000, 16'h0000, 16'h0AAA, 16'h0555, 1'b0, 16'h0001, 5'b00000, 16'h0AAA, 16'h0555};
      vecs[11] = '{16'h0000, 16'h5800, 16'h1234, 16'h0000, 16'h0000, 1'b0, 16'h0002, 5'b10000, 16'h0000, 16'h0000};
      vecs[12] = '{16'h0000, 16'hC000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 5'b10000, 16'h0000, 16'h0000};
      vecs[13] = '{16'h0000, 16'h3800, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0002, 5'b00000, 16'h0000, 16'h0000};
      vecs[14] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 5'b00000, 16'h0000, 16'h0000};
      vecs[15] = '{16'hFFFF, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b10000, 16'h0000, 16'h0000};
      // imm of the instruction at 0xFFFF is read from 0x0000, which holds the 0x2800 prefix
      vecs[16] = '{16'hFFFF, 16'h2800, 16'h2800, 16'h0000, 16'h0000, 1'b0, 16'h2800, 5'b00000, 16'h0000, 16'h0000};
      vecs[17] = '{16'h0000, 16'h8800, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0002, 5'b00000, 16'h0000, 16'h0000};
      vecs[18] = '{16'h0000, 16'h7000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 5'b10000, 16'h0000, 16'h0000};
      vecs[19] = '{16'h0000, 16'hA800, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0002, 5'b00000, 16'h0000, 16'h0000};

      // Reset state
      tick();
      chk("reset_pc", pc, 16'h0000);
      chk("reset_addr2", instr_addr2, 16'h0001);
      chk("reset_sp", sp, 4'd0);
      chk("reset_flags", {fault, halted}, 2'b00);
      chk("reset_da", {data_addr1, data_addr2}, 32'h0);
      chk("reset_stb", strobes(), 5'b00000);

      // Single-instruction vectors; non-zero addresses are reached via a JMP imm at 0
      for (int i = 0; i < 20; i++) begin
         v  = vecs[i];
         a1 = v.addr + 16'd1;
         mem[v.addr] = v.ins;
         mem[a1]     = v.immw;
         if (v.addr != 16'h0000) begin
            mem[0] = 16'h2800;
            mem[1] = v.addr;
         end
         rddata = v.rd; rsdata = v.rs; jump = v.jmp;
         reset = 1'b1;
         tick();
         reset = 1'b0;
         if (v.addr != 16'h0000) begin
            tick();
            tick();
         end
         tick();
         chk($sformatf("vec%0d_exec_stb", i), strobes(), v.exp_stb);
         tick();
         chk($sformatf("vec%0d_pc", i), pc, v.exp_pc);
         chk($sformatf("vec%0d_da", i), {data_addr1, data_addr2}, {v.exp_da1, v.exp_da2});
         chk($sformatf("vec%0d_fetch_stb", i), strobes(), 5'b00000);
      end
      rddata = '0; rsdata = '0; jump = 1'b0;

      // ADD then STP: rd_wen only in cycle 2, HALT at pc 2, run resumes
      mem[0] = 16'h4000; mem[1] = 16'hF800; mem[2] = 16'hF800;
      reset = 1'b1;
      tick();
      trace[0] = rd_wen;
      reset = 1'b0;
      for (int c = 1; c < 6; c++) begin
         tick();
         trace[c] = rd_wen;
      end
      chk("stp_rd_wen_trace", trace, 6'b000010);
      chk("stp_halted", halted, 1'b1);
      chk("stp_pc", pc, 16'h0002);
      run = 1'b1;
      tick();
      chk("run_fetch_halted", halted, 1'b0);
      chk("run_fetch_addr", {instr_addr1, instr_addr2}, {16'h0002, 16'h0003});
      tick();
      tick();
      chk("stp2_halt_pc", {halted, pc}, {1'b1, 16'h0003});
      tick();
      chk("stp2_one_cycle_halt", halted, 1'b0);
      run = 1'b0;

      // CAL 0x0100 then RTN
      mem[0] = 16'h0800; mem[1] = 16'h0100; mem[16'h0100] = 16'hE000;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk("cal_pc", pc, 16'h0100);
      chk("cal_sp", sp, 4'd1);
      tick();
      tick();
      chk("rtn_pc", pc, 16'h0002);
      chk("rtn_sp", sp, 4'd0);

      // Nine nested CALs: the ninth overflows
      mem[0] = 16'h2800; mem[1] = 16'h0200;
      for (int k = 0; k < 9; k++) begin
         mem[16'h0200 + 16'(k * 16)]     = 16'h0800;
         mem[16'h0201 + 16'(k * 16)]     = 16'h0200 + 16'((k + 1) * 16);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 8; k++) begin
         tick();
         tick();
      end
      chk("nest8_sp", sp, 4'd8);
      chk("nest8_pc", pc, 16'h0280);
      tick();
      tick();
      chk("nest9_fault", {fault, halted}, 2'b11);
      chk("nest9_pc_held", pc, 16'h0280);
      chk("nest9_sp_held", sp, 4'd8);
      tick();
      chk("nest9_fault_sticky", fault, 1'b1);

      // RTN on empty stack; run cannot leave FAULT, reset does
      mem[0] = 16'hE000;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk("rtn_empty_fault", {fault, halted}, 2'b11);
      run = 1'b1;
      tick();
      tick();
      chk("fault_ignores_run", {fault, halted}, 2'b11);
      run = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("fault_cleared", {fault, halted, pc}, {2'b00, 16'h0000});

      // Reset during EXEC of a CAL: no push, then a clean CAL afterwards
      mem[0] = 16'h0800; mem[1] = 16'h0100;
      tick();
      reset = 1'b1;
      tick();
      chk("rst_exec_pc_sp", {pc, sp}, {16'h0000, 4'd0});
      chk("rst_exec_state", halted, 1'b0);
      reset = 1'b0;
      tick();
      tick();
      chk("post_rst_cal", {pc, sp}, {16'h0100, 4'd1});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Registered successor to the combinational instruction decoder.
- Owns the program counter and sequences each instruction through a FETCH/EXEC pair.
- Decodes the 16-bit ISA into one-cycle write strobes and resolves JMP, CMP-skip, CAL/RTN and STP.
- Provides a parametrised hardware return stack for CAL/RTN.
- Sits between the dual-port instruction memory (synchronous read, 1-cycle latency), the register file and the data memory.

Parameters:
- DATA_W, 16: instruction, register data and immediate width.
- ADDR_W, 16: PC and memory address width. Requires ADDR_W <= DATA_W.
- STACK_DEPTH, 8: return-stack entries; power of 2, >= 2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- run  in  1  leave HALT and resume at the current PC (level)
- instr  in  DATA_W  instruction word, port 1 (addressed by instr_addr1 in the previous cycle)
- imm  in  DATA_W  second word N, port 2 (addressed by instr_addr2)
- rddata  in  DATA_W  Rd register value
- rsdata  in  DATA_W  Rs register value
- jump  in  1  compare-true flag from the ALU, valid in EXEC
- instr_addr1  out  ADDR_W  equals pc
- instr_addr2  out  ADDR_W  equals pc+1, mod 2^ADDR_W
- pc  out  ADDR_W  current program counter
- data_addr1, data_addr2  out  ADDR_W  registered data-memory addresses
- rd_wen, rs_wen, data_wen1, data_wen2  out  1  write strobes, one cycle, EXEC only
- mux1_sel  out  1  selects store data path (PST)
- halted  out  1  in HALT
- fault  out  1  sticky; return-stack overflow or underflow
- sp  out  log2(STACK_DEPTH)+1  stack occupancy

Behaviour:
Decode fields:
- op = instr[15:12]; type = instr[11].
- Length is 2 words if type = 1, except STP (11111), which is 1 word. Otherwise length is 1.
- Encodings (op,type): NOP 0000,0; CAL 0000,1; CMP 0001,x; JMP 0010,x; ADD 0100,x; SUB 0101,x; MAS 0110,x; MOV 0111,x; PLD 1000,0; PST 1001,0; SET 1011,x; LSL 1100,0; LSR 1101,0; RTN 1110,0; STP 1111,1.
- Any other encoding executes as NOP, using its length.

Reset:
- pc = RESET_PC; state = FETCH; sp = 0; fault = 0; data_addr1/2 = 0.
- All strobes and mux1_sel = 0; halted = 0.

States:
- FETCH (1 cycle): present addresses; no strobes. Next state is EXEC.
- EXEC (1 cycle): decode instr/imm; assert strobes; update pc. Next state is FETCH, or HALT/FAULT.
- HALT: pc is held. When run = 1, go to FETCH.
- FAULT: terminal; fault = 1, halted = 1. Only reset exits.
- Throughput: 2 cycles per instruction. Strobes are combinational from the EXEC state and registered instr, and are zero in every other state.

EXEC actions (default next pc = pc + len, mod 2^ADDR_W):
- ADD/SUB/MAS/MOV/LSL/LSR: rd_wen = 1.
- PLD: rd_wen = instr[3]; rs_wen = instr[2].
- PST: data_wen1 = instr[3]; data_wen2 = instr[2]; mux1_sel = 1.
- SET: data_addr1 <= rddata[ADDR_W-1:0]; data_addr2 <= rsdata[ADDR_W-1:0]. Both hold until the next SET.
- CMP: if jump = 1, pc <= pc + len + instr[1:0] (skip 0-3 words); otherwise pc + len.
- JMP: pc <= type ? imm[ADDR_W-1:0] : rddata[ADDR_W-1:0].
- CAL:
  - Not full: push pc+2 and set pc <= imm.
  - Full (sp = STACK_DEPTH): go to FAULT; pc and stack unchanged.
- RTN:
  - Not empty: pop and set pc <= top.
  - Empty (sp = 0): go to FAULT.
- STP: pc <= pc+1, then HALT. If run is already high, HALT lasts 1 cycle.

Boundaries:
- pc arithmetic wraps modulo 2^ADDR_W; e.g. a 2-word instruction at 0xFFFF fetches imm from 0x0000.
- reset in any state, mid-instruction included, overrides everything within one cycle.
- run is ignored outside HALT.

Decomposition:
- Package ctrl_pkg: opcode constants; the state enum {FETCH, EXEC, HALT, FAULT}; an is_two_word(op,type) function.
- Sub-module ret_stack, parametrised by STACK_DEPTH and ADDR_W.
  - Ports: push, pop, din, dout (top), sp, full, empty.
  - Synchronous; push and pop are never asserted together.

Test Plan:
- Sequence: reset; mem[0]=0x4000 (ADD), mem[1]=0xF800 (STP) -> rd_wen high exactly in cycle 2; halted=1 with pc=0x0002; run pulse -> FETCH at 0x0002.
- JMP immediate: mem[0]=0x2800, mem[1]=0x0040 -> pc=0x0040. JMP register with rddata=0x0123 -> pc=0x0123.
- CMP at 0x0010, instr=0x1003, jump=1 -> pc=0x0014. Same with jump=0 -> pc=0x0011.
- CAL nesting: CAL 0x0100 at 0x0000, RTN at 0x0100 -> pc=0x0002 and sp back to 0. Nine nested CALs (depth 8) -> fault=1 on the 9th, pc held.
- RTN with empty stack -> FAULT; only reset clears it. PST 0x900C -> data_wen1 and data_wen2 high for one cycle; SET with rddata=0x0AAA, rsdata=0x0555 -> data_addr1/2 updated.
- Assert reset during the EXEC of a CAL -> no push; pc=RESET_PC and sp=0 on the next cycle.
